// File: rtl/pcie_datalink_pkg.sv
// Shared DLLP definitions for the link-layer transmit path: type codes, byte layout, scheduler states.
package pcie_datalink_pkg;

  typedef enum logic [7:0] {
    ACK          = 8'h00,
    NAK          = 8'h10,
    UPDATEFC_P   = 8'h80,
    UPDATEFC_NP  = 8'h90,
    UPDATEFC_CPL = 8'hA0
  } dllp_type_e;

  // byte0 occupies the least significant bits so the struct maps straight onto tdata
  typedef struct packed {
    logic [7:0] byte3;
    logic [7:0] byte2;
    logic [7:0] byte1;
    logic [7:0] byte0;
  } dllp_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_RDY,
    FC_NEXT
  } sched_state_e;

  function automatic dllp_t acknack_dllp(dllp_type_e kind, logic [11:0] seq);
    dllp_t d;
    d       = '0;
    d.byte0 = kind;
    d.byte2 = {4'h0, seq[11:8]};
    d.byte3 = seq[7:0];
    return d;
  endfunction

endpackage

// File: rtl/dllp_fc_encode.sv
// Combinational UpdateFC packer: DLLP type plus header/data credits into one 32-bit DLLP.
// No latency, no flow control of its own.
module dllp_fc_encode
  import pcie_datalink_pkg::*;
(
  input  logic [7:0]  fc_type,
  input  logic [7:0]  hdr_fc,
  input  logic [11:0] data_fc,
  output logic [31:0] dllp
);

  dllp_t d;

  always_comb begin
    d       = '0;
    d.byte0 = fc_type;
    d.byte1 = {2'b00, hdr_fc[7:2]};
    d.byte2 = {hdr_fc[1:0], 2'b00, data_fc[11:8]};
    d.byte3 = data_fc[7:0];
  end

  assign dllp = d;

endmodule

// File: rtl/pcie_dllp_tx_scheduler.sv
// DLLP transmit scheduler: Nak > timed Ack > UpdateFC rounds, one registered beat at a time.
// Pending Nak reaches tvalid two cycles after its strobe; a held beat stays stable until tready.
module pcie_dllp_tx_scheduler
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 3,
  parameter int ACK_TIMER      = 64,
  parameter int UPDATEFC_TIMER = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  link_active_i,
  input  logic [11:0]           seq_num_i,
  input  logic                  seq_num_vld_i,
  input  logic                  seq_num_acknack_i,
  input  logic [7:0]            rx_fc_ph_i,
  input  logic [11:0]           rx_fc_pd_i,
  input  logic [7:0]            rx_fc_nph_i,
  input  logic [11:0]           rx_fc_npd_i,
  input  logic [7:0]            rx_fc_cplh_i,
  input  logic [11:0]           rx_fc_cpld_i,
  input  logic                  fc_update_req_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  output logic [USER_WIDTH-1:0] m_axis_tuser_o,
  input  logic                  m_axis_tready_i
);

  localparam int AW = $clog2(ACK_TIMER);
  localparam int FW = $clog2(UPDATEFC_TIMER);

  sched_state_e  state;
  logic          nak_pend, nak_sched, ack_pend, fc_pend, in_round;
  logic [11:0]   ack_seq;
  logic [AW-1:0] ack_tmr;
  logic [FW-1:0] fc_tmr;
  logic [1:0]    fc_idx;

  logic          good_evt, bad_evt, ack_elig, fc_wrap, hs;
  logic [11:0]   sent_seq;
  dllp_type_e    fc_type;
  logic [7:0]    fc_hdr;
  logic [11:0]   fc_data;
  logic [31:0]   fc_dllp;
  logic          ld_nak, ld_ack, ld_fc;
  logic [31:0]   ld_dat;

  assign good_evt = link_active_i & seq_num_vld_i & seq_num_acknack_i;
  assign bad_evt  = link_active_i & seq_num_vld_i & ~seq_num_acknack_i & ~nak_sched;
  assign ack_elig = ack_pend & (ack_tmr == AW'(ACK_TIMER - 1));
  assign fc_wrap  = (fc_tmr == FW'(UPDATEFC_TIMER - 1));
  assign hs       = m_axis_tvalid_o & m_axis_tready_i;
  // sequence number of the Ack currently on the bus, recovered from its own bytes
  assign sent_seq = {m_axis_tdata_o[19:16], m_axis_tdata_o[31:24]};
  assign m_axis_tuser_o = '0;

  always_comb begin
    fc_type = UPDATEFC_CPL;
    fc_hdr  = rx_fc_cplh_i;
    fc_data = rx_fc_cpld_i;
    case (fc_idx)
      2'd0: begin fc_type = UPDATEFC_P;  fc_hdr = rx_fc_ph_i;  fc_data = rx_fc_pd_i;  end
      2'd1: begin fc_type = UPDATEFC_NP; fc_hdr = rx_fc_nph_i; fc_data = rx_fc_npd_i; end
      default: ;
    endcase
  end

  dllp_fc_encode u_fc_encode (
    .fc_type (fc_type),
    .hdr_fc  (fc_hdr),
    .data_fc (fc_data),
    .dllp    (fc_dllp)
  );

  // Within a round only a Nak may cut in; Acks wait for the round to finish.
  always_comb begin
    ld_nak = 1'b0;
    ld_ack = 1'b0;
    ld_fc  = 1'b0;
    if (link_active_i && (state == IDLE || state == FC_NEXT)) begin
      if (nak_pend)               ld_nak = 1'b1;
      else if (state == FC_NEXT)  ld_fc  = 1'b1;
      else if (ack_elig)          ld_ack = 1'b1;
      else if (fc_pend)           ld_fc  = 1'b1;
    end
    ld_dat = fc_dllp;
    if (ld_nak)      ld_dat = acknack_dllp(NAK, ack_seq);
    else if (ld_ack) ld_dat = acknack_dllp(ACK, ack_seq);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= IDLE;
      nak_pend        <= 1'b0;
      nak_sched       <= 1'b0;
      ack_pend        <= 1'b0;
      fc_pend         <= 1'b0;
      in_round        <= 1'b0;
      ack_seq         <= '0;
      ack_tmr         <= '0;
      fc_tmr          <= '0;
      fc_idx          <= '0;
      m_axis_tdata_o  <= '0;
      m_axis_tkeep_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tlast_o  <= 1'b0;
    end else begin
      fc_tmr <= fc_wrap ? '0 : fc_tmr + 1'b1;
      if (ack_pend && !ack_elig) ack_tmr <= ack_tmr + 1'b1;

      case (state)
        IDLE, FC_NEXT: begin
          if (ld_nak || ld_ack || ld_fc) begin
            m_axis_tdata_o  <= ld_dat;
            m_axis_tkeep_o  <= '1;
            m_axis_tvalid_o <= 1'b1;
            m_axis_tlast_o  <= 1'b1;
            state           <= LOAD;
            if (ld_fc && state == IDLE) begin
              fc_pend  <= 1'b0;
              in_round <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        LOAD, WAIT_RDY: begin
          state <= WAIT_RDY;
          if (hs) begin
            m_axis_tkeep_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            m_axis_tlast_o  <= 1'b0;
            state           <= IDLE;
            if (m_axis_tdata_o[7:0] == NAK) begin
              nak_pend <= 1'b0;
              if (in_round && link_active_i) state <= FC_NEXT;
            end else if (m_axis_tdata_o[7:0] == ACK) begin
              // a newer sequence arrived while this Ack was in flight: keep it pending
              ack_pend <= ack_pend & (ack_seq != sent_seq);
              ack_tmr  <= '0;
            end else if (fc_idx == 2'd2 || !in_round || !link_active_i) begin
              in_round <= 1'b0;
              fc_idx   <= '0;
            end else begin
              fc_idx <= fc_idx + 1'b1;
              state  <= FC_NEXT;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // new events are applied last so a set beats a same-cycle clear
      if (link_active_i && (fc_wrap || fc_update_req_i)) fc_pend <= 1'b1;
      if (good_evt) begin
        ack_seq   <= seq_num_i;
        ack_pend  <= 1'b1;
        nak_sched <= 1'b0;
      end
      if (bad_evt) begin
        nak_pend  <= 1'b1;
        nak_sched <= 1'b1;
        ack_seq   <= seq_num_i;
        ack_pend  <= 1'b0;
        ack_tmr   <= '0;
      end

      if (!link_active_i) begin
        nak_pend  <= 1'b0;
        nak_sched <= 1'b0;
        ack_pend  <= 1'b0;
        fc_pend   <= 1'b0;
        in_round  <= 1'b0;
        ack_tmr   <= '0;
        fc_tmr    <= '0;
        fc_idx    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_dllp_tx_scheduler.sv
// Directed + randomized bench for the DLLP transmit scheduler with a beat-level expectation model.
module tb_pcie_dllp_tx_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, link, vld, acknack, req, tready;
  logic [11:0] seq;
  logic [7:0]  ph, nph, cplh;
  logic [11:0] pd, npd, cpld;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast;
  logic [2:0]  tuser;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] beat_q[$];
  logic [31:0] exp_q[$];
  int          beat_cyc_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;

  pcie_dllp_tx_scheduler dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .link_active_i     (link),
    .seq_num_i         (seq),
    .seq_num_vld_i     (vld),
    .seq_num_acknack_i (acknack),
    .rx_fc_ph_i        (ph),
    .rx_fc_pd_i        (pd),
    .rx_fc_nph_i       (nph),
    .rx_fc_npd_i       (npd),
    .rx_fc_cplh_i      (cplh),
    .rx_fc_cpld_i      (cpld),
    .fc_update_req_i   (req),
    .m_axis_tdata_o    (tdata),
    .m_axis_tkeep_o    (tkeep),
    .m_axis_tvalid_o   (tvalid),
    .m_axis_tlast_o    (tlast),
    .m_axis_tuser_o    (tuser),
    .m_axis_tready_i   (tready)
  );

  // Expected DLLP images, built byte by byte from the wire format
  function automatic logic [31:0] acknak_enc(logic [7:0] t, logic [11:0] s);
    return {s[7:0], 4'h0, s[11:8], 8'h00, t};
  endfunction

  function automatic logic [31:0] fc_enc(logic [7:0] t, logic [7:0] h, logic [11:0] d);
    return {d[7:0], h[1:0], 2'b00, d[11:8], 2'b00, h[7:2], t};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: handshakes, held-beat stability and sideband values
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", {31'd0, tvalid}, 32'd1);
        chk("stall_tdata", tdata, prev_dat);
      end
      if (tvalid) begin
        chk("tkeep", {28'd0, tkeep}, 32'hF);
        chk("tlast", {31'd0, tlast}, 32'd1);
        chk("tuser", {29'd0, tuser}, 32'd0);
      end
      if (tvalid && tready) begin
        beat_q.push_back(tdata);
        beat_cyc_q.push_back(cyc);
      end
      prev_stall = tvalid && !tready;
      prev_dat   = tdata;
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic evt(logic [11:0] s, logic good);
    seq = s; acknack = good; vld = 1'b1;
    step(1);
    vld = 1'b0;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    step(1);
    req = 1'b0;
  endtask

  task automatic link_cycle();
    link = 1'b0;
    step(3);
    link = 1'b1;
    step(1);
    beat_q.delete();
    beat_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_vld(int budget);
    int n = 0;
    while (!tvalid && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_tvalid", {31'd0, tvalid}, 32'd1);
  endtask

  task automatic cmp(string tag);
    chk({tag, "_count"}, beat_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < beat_q.size()) ? beat_q[i] : 32'hx, exp_q[i]);
  endtask

  function automatic logic [31:0] beat_at(int i);
    return (i < beat_q.size()) ? beat_q[i] : 32'hx;
  endfunction

  function automatic int cyc_at(int i);
    return (i < beat_cyc_q.size()) ? beat_cyc_q[i] : -1000;
  endfunction

  initial begin
    int t0, lat;
    logic [11:0] base, last, a, b, g;

    rst_n = 1'b0; link = 1'b1; vld = 1'b0; acknack = 1'b0; seq = '0;
    req = 1'b0; tready = 1'b1;
    ph = '0; pd = '0; nph = '0; npd = '0; cplh = '0; cpld = '0;
    step(3);
    chk("reset_tvalid", {31'd0, tvalid}, 32'd0);
    chk("reset_tdata", tdata, 32'd0);
    chk("reset_tkeep", {28'd0, tkeep}, 32'd0);
    chk("reset_tlast", {31'd0, tlast}, 32'd0);
    chk("reset_tuser", {29'd0, tuser}, 32'd0);
    rst_n = 1'b1;

    // Single good TLP -> one timed Ack
    link_cycle();
    t0 = cyc;
    evt(12'h005, 1'b1);
    step(100);
    exp_q = '{acknak_enc(8'h00, 12'h005)};
    cmp("ack_single");
    chk("ack_spec_vector", beat_at(0), 32'h05000000);
    lat = cyc_at(0) - t0;
    chk("ack_latency_window", {31'd0, (lat >= 60 && lat <= 70)}, 32'd1);

    // Burst of good TLPs coalesces into one Ack with the newest seq
    for (int i = 0; i < 3; i++) begin
      link_cycle();
      base = (i == 0) ? 12'h000 : 12'($urandom_range(0, 4095));
      last = base;
      for (int j = 1; j <= 3; j++) begin
        last = base + 12'(j);
        evt(last, 1'b1);
        step($urandom_range(0, 2));
      end
      step(100);
      exp_q = '{acknak_enc(8'h00, last)};
      cmp("ack_coalesce");
    end

    // One Nak per error episode
    link_cycle();
    t0 = cyc;
    evt(12'h7FF, 1'b0);
    step(2);
    evt(12'($urandom), 1'b0);
    step(20);
    exp_q = '{acknak_enc(8'h10, 12'h7FF)};
    cmp("nak_once");
    chk("nak_spec_vector", beat_at(0), 32'hFF070010);
    chk("nak_latency", 32'(cyc_at(0) - t0), 32'd2);
    beat_q.delete();
    beat_cyc_q.delete();
    g = 12'($urandom);
    b = 12'($urandom);
    evt(g, 1'b1);
    step(1);
    evt(b, 1'b0);
    step(100);
    exp_q = '{acknak_enc(8'h10, b)};
    cmp("nak_new_episode");

    // On-demand UpdateFC round
    link_cycle();
    ph = 8'h20; pd = 12'h100; nph = 8'h10; npd = 12'h000; cplh = 8'h00; cpld = 12'h000;
    pulse_req();
    step(20);
    exp_q = '{fc_enc(8'h80, ph, pd), fc_enc(8'h90, nph, npd), fc_enc(8'hA0, cplh, cpld)};
    cmp("fc_round");
    chk("fc_p_spec_vector", beat_at(0), 32'h00010880);
    chk("fc_spacing_p_np", 32'(cyc_at(1) - cyc_at(0)), 32'd2);
    chk("fc_spacing_np_cpl", 32'(cyc_at(2) - cyc_at(1)), 32'd2);

    // Request during a round schedules a second round
    link_cycle();
    ph = 8'($urandom); pd = 12'($urandom); nph = 8'($urandom);
    npd = 12'($urandom); cplh = 8'($urandom); cpld = 12'($urandom);
    pulse_req();
    step(2);
    pulse_req();
    step(30);
    exp_q = '{fc_enc(8'h80, ph, pd), fc_enc(8'h90, nph, npd), fc_enc(8'hA0, cplh, cpld),
              fc_enc(8'h80, ph, pd), fc_enc(8'h90, nph, npd), fc_enc(8'hA0, cplh, cpld)};
    cmp("fc_double");

    // Stalled Ack stays stable; Nak arriving meanwhile follows it
    link_cycle();
    tready = 1'b0;
    a = 12'($urandom);
    b = 12'($urandom);
    evt(a, 1'b1);
    wait_vld(100);
    step(5);
    evt(b, 1'b0);
    step(15);
    chk("stall_ack_hold", tdata, acknak_enc(8'h00, a));
    tready = 1'b1;
    step(10);
    exp_q = '{acknak_enc(8'h00, a), acknak_enc(8'h10, b)};
    cmp("ack_then_nak");
    chk("nak_after_ack_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd2);

    // Nak cuts into an UpdateFC round, round then resumes
    link_cycle();
    tready = 1'b0;
    ph = 8'($urandom); pd = 12'($urandom); nph = 8'($urandom);
    npd = 12'($urandom); cplh = 8'($urandom); cpld = 12'($urandom);
    pulse_req();
    wait_vld(10);
    b = 12'($urandom);
    evt(b, 1'b0);
    step(3);
    tready = 1'b1;
    step(20);
    exp_q = '{fc_enc(8'h80, ph, pd), acknak_enc(8'h10, b),
              fc_enc(8'h90, nph, npd), fc_enc(8'hA0, cplh, cpld)};
    cmp("nak_mid_round");

    // Link drop mid-round: current beat drains, everything else discarded
    link_cycle();
    tready = 1'b0;
    pulse_req();
    wait_vld(10);
    link = 1'b0;
    evt(12'($urandom), 1'b1);
    pulse_req();
    step(4);
    tready = 1'b1;
    step(10);
    exp_q = '{fc_enc(8'h80, ph, pd)};
    cmp("link_down_drain");
    chk("link_down_idle", {31'd0, tvalid}, 32'd0);
    beat_q.delete();
    link = 1'b1;
    step(100);
    chk("link_down_no_beats", beat_q.size(), 32'd0);

    // Reset pulse mid-round
    link_cycle();
    tready = 1'b0;
    pulse_req();
    wait_vld(10);
    step(2);
    rst_n = 1'b0;
    step(1);
    chk("rst_mid_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_mid_tdata", tdata, 32'd0);
    rst_n = 1'b1;
    tready = 1'b1;
    beat_q.delete();
    step(50);
    chk("rst_no_beats", beat_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcie_dllp_tx_scheduler.md
Name: pcie_dllp_tx_scheduler

Overview:
- Link-layer DLLP transmit scheduler.
- Collects Ack/Nak events from the DLLP receive path and periodic or on-demand UpdateFC requests, then encodes each as a 4-byte DLLP.
- Issues DLLPs one at a time, in priority order, on a single AXI-Stream master.
- Output feeds one slave port of the DLLP-to-PHY arbiter mux; CRC16 and framing are added downstream.

Parameters:
- DATA_WIDTH, 32, stream width; fixed at 32 (one DLLP per beat).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 3, tuser width; always driven 0.
- ACK_TIMER, 64, cycles from first unacknowledged good TLP to forced Ack.
- UPDATEFC_TIMER, 256, cycles between periodic UpdateFC rounds.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; active-low, synchronous
- link_active_i  in  1  DL_Active; scheduler enabled only when high
- seq_num_i  in  12  sequence number from receive path
- seq_num_vld_i  in  1  event strobe, one cycle
- seq_num_acknack_i  in  1  1 = good TLP received (seq_num_i = its seq); 0 = bad TLP (seq_num_i = last good seq)
- rx_fc_ph_i  in  8  posted header credits to advertise
- rx_fc_pd_i  in  12  posted data credits
- rx_fc_nph_i  in  8  non-posted header credits
- rx_fc_npd_i  in  12  non-posted data credits
- rx_fc_cplh_i  in  8  completion header credits
- rx_fc_cpld_i  in  12  completion data credits
- fc_update_req_i  in  1  pulse: credits released, request an immediate UpdateFC round
- m_axis_tdata_o  out  DATA_WIDTH  DLLP bytes; byte0 at [7:0]
- m_axis_tkeep_o  out  KEEP_WIDTH  all ones when valid
- m_axis_tvalid_o  out  1
- m_axis_tlast_o  out  1  always 1 when valid
- m_axis_tuser_o  out  USER_WIDTH  0
- m_axis_tready_i  in  1

Behaviour:
- Reset: tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0; all timers, flags, and the pending round cleared; state IDLE.

Encoding:
- Ack: byte0=0x00, byte1=0x00, byte2[3:0]=seq[11:8], byte3=seq[7:0].
- Nak: byte0=0x10; bytes1-3 as for Ack.
- UpdateFC types: P byte0=0x80, NP byte0=0x90, Cpl byte0=0xA0 (VC0).
  - byte1[5:0]=HdrFC[7:2]
  - byte2[7:6]=HdrFC[1:0]
  - byte2[3:0]=DataFC[11:8]
  - byte3=DataFC[7:0]
  - All other bits 0.
- Credit values are sampled in the cycle the beat is loaded.

Ack/Nak tracking:
- Good event: ack_seq <= seq_num_i; ack_pend <= 1; nak_sched <= 0; ack timer starts if idle.
- Bad event with nak_sched=0: nak_pend <= 1; nak_sched <= 1; ack_seq <= seq_num_i; ack_pend <= 0; ack timer cleared.
- Bad event with nak_sched=1: ignored (one Nak per error episode).
- Ack becomes eligible when the ack timer reaches ACK_TIMER-1. The timer saturates there until the Ack is sent.
- Ack always carries the newest ack_seq at load time (coalescing).

UpdateFC:
- fc_pend is set when the UpdateFC timer wraps at UPDATEFC_TIMER-1, or on fc_update_req_i.
- A round sends P, then NP, then Cpl; fc_pend clears when the round starts.
- Requests during a round re-set fc_pend, so another round follows.

State machine IDLE / LOAD / WAIT_RDY / FC_NEXT:
- IDLE: when link_active_i, pick by priority Nak > eligible Ack > fc_pend; LOAD the beat next cycle.
- LOAD: drive tvalid=1; go to WAIT_RDY.
- WAIT_RDY: tdata stable while tready=0. On handshake:
  - Nak: clear nak_pend.
  - Ack: clear ack_pend, clear timer.
  - FC: go to FC_NEXT (P→NP→Cpl); after Cpl, return to IDLE.
- A Nak arriving mid-round is served after the current beat and before the next FC beat; the round then resumes.
- Event latency: idle to tvalid = 2 cycles after the strobe for a Nak. Back-to-back handshakes allow one DLLP per 2 cycles.
- Event registered in the same cycle as a handshake: it is not lost. Pending flags are set/clear-prioritised so set wins for new events.

Link down (link_active_i=0):
- No new beat is loaded.
- A beat already valid is held until accepted, then the block returns to IDLE.
- Timers, pending flags, and nak_sched are cleared; any FC round in progress is abandoned.

Decomposition:
- pcie_datalink_pkg: dllp_type_e (ACK=0x00, NAK=0x10, UPDATEFC_P=0x80, UPDATEFC_NP=0x90, UPDATEFC_CPL=0xA0), packed dllp_t struct, and scheduler state enum.
- Sub-module dllp_fc_encode: combinational UpdateFC byte packer (type, hdr, data → 32 bits).

Test Plan:
- Good TLP seq 0x005, tready=1 → after 64 cycles one beat 0x05000000 (byte0=0x00, byte3=0x05), tlast=1, tkeep=0xF.
- Good seq 0x001, 0x002, 0x003 within 10 cycles → single Ack carrying 0x003, with no earlier Ack.
- Bad event seq 0x7FF, then a second bad event → exactly one Nak, tdata=0xFF070010; second event ignored until a good TLP arrives.
- fc_update_req_i with ph=0x20, pd=0x100, nph=0x10, npd=0x000, cplh=0x00, cpld=0x000 → three beats in order P, NP, Cpl; P beat = bytes 0x80, 0x08, 0x01, 0x00.
- tready held 0 for 20 cycles during an Ack while a Nak arrives → Ack tdata stable throughout, then Nak follows the Ack handshake.
- link_active_i dropped during an FC round with tready=0 → current beat completes on tready, no further beats, all pending flags clear; rst_ni low for one cycle mid-round → tvalid=0 on the next cycle.
